// File: rtl/jam_pkg.sv
// Shared types and elaboration-time helpers for the job-assignment search engine.
package jam_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_NEXT  = 2'd2,
    S_DONE  = 2'd3
  } jam_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // One guard bit per doubling of N keeps N * (2^CW - 1) from overflowing.
  function automatic int sum_w(input int n, input int cw);
    return cw + $clog2(n);
  endfunction

  function automatic longint factorial(input int n);
    longint r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a packed permutation; flags the
// final (fully descending) permutation.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N*IW-1:0] perm_i,
  output logic [N*IW-1:0] next_o,
  output logic            is_last_o
);

  logic [IW-1:0] p [N];
  logic [IW-1:0] s [N];
  logic [IW-1:0] pv;
  logic [IW-1:0] sv;
  logic          found;
  int            piv;
  int            sw;

  always_comb begin
    for (int k = 0; k < N; k++) p[k] = perm_i[k*IW +: IW];

    found = 1'b0;
    piv   = 0;
    for (int k = 0; k < N - 1; k++) begin
      if (p[k] < p[k+1]) begin
        found = 1'b1;
        piv   = k;
      end
    end

    pv = '0;
    for (int k = 0; k < N; k++) if (k == piv) pv = p[k];

    // The suffix right of the pivot is descending, so the last larger entry is the smallest larger one.
    sw = piv;
    for (int k = 0; k < N; k++) if (k > piv && p[k] > pv) sw = k;

    sv = '0;
    for (int k = 0; k < N; k++) if (k == sw) sv = p[k];

    for (int k = 0; k < N; k++) s[k] = (k == piv) ? sv : ((k == sw) ? pv : p[k]);

    next_o = '0;
    for (int k = 0; k < N; k++) begin
      next_o[k*IW +: IW] = s[k];
      for (int m = 0; m < N; m++) begin
        if (k > piv && m == N + piv - k) next_o[k*IW +: IW] = s[m];
      end
    end

    is_last_o = ~found;
  end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N! job-assignment search: walks every permutation in lexicographic
// order, fetching one cost per cycle, and keeps min, tie count and first optimum.
module jam_param
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int IW  = idx_w(N),
  parameter int SW  = sum_w(N, CW),
  parameter int MCW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              prune_en,
  output logic              busy,
  output logic [IW-1:0]     W,
  output logic [IW-1:0]     J,
  input  logic [CW-1:0]     Cost,
  output logic [SW-1:0]     MinCost,
  output logic [MCW-1:0]    MatchCount,
  output logic [N*IW-1:0]   BestPerm,
  output logic              Valid
);

  if (N < 2 || N > 8 || longint'(factorial(N)) >= (64'd1 << MCW)) begin : g_param_check
    $error("jam_param: N must be 2..8 and MCW must hold N!");
  end

  function automatic logic [N*IW-1:0] identity_perm();
    logic [N*IW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(k);
    return r;
  endfunction

  localparam logic [N*IW-1:0] IDENT = identity_perm();

  jam_state_e      state_q, state_d;
  logic [N*IW-1:0] perm_q, perm_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   j_q, j_d;
  logic [SW-1:0]   min_q, min_d;
  logic [MCW-1:0]  cnt_q, cnt_d;
  logic [N*IW-1:0] best_q, best_d;
  logic            valid_q, valid_d;
  logic            prune_q, prune_d;

  logic [N*IW-1:0] perm_nx;
  logic            is_last;
  logic [SW-1:0]   acc_n;
  logic [IW-1:0]   w_inc;

  jam_next_perm #(.N(N), .IW(IW)) u_next_perm (
    .perm_i    (perm_q),
    .next_o    (perm_nx),
    .is_last_o (is_last)
  );

  always_comb begin
    state_d = state_q;
    perm_d  = perm_q;
    acc_d   = acc_q;
    w_d     = w_q;
    j_d     = j_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    valid_d = valid_q;
    prune_d = prune_q;
    acc_n   = acc_q + SW'(Cost);
    w_inc   = w_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d   = '0;
          min_d   = '1;
          cnt_d   = '0;
          valid_d = 1'b0;
          prune_d = prune_en;
          perm_d  = IDENT;
          w_d     = '0;
          j_d     = IDENT[IW-1:0];
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Strictly greater only: an equal partial sum may still tie and must be counted.
        if (prune_q && acc_n > min_q) begin
          state_d = S_NEXT;
        end else if (w_q != IW'(N - 1)) begin
          acc_d = acc_n;
          w_d   = w_inc;
          for (int k = 0; k < N; k++) if (IW'(k) == w_inc) j_d = perm_q[k*IW +: IW];
        end else begin
          if (acc_n < min_q) begin
            min_d  = acc_n;
            cnt_d  = MCW'(1);
            best_d = perm_q;
          end else if (acc_n == min_q) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        acc_d = '0;
        w_d   = '0;
        if (is_last) begin
          j_d     = '0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          perm_d  = perm_nx;
          j_d     = perm_nx[IW-1:0];
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      perm_q  <= IDENT;
      acc_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      min_q   <= '1;
      cnt_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
      prune_q <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      j_q     <= j_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      valid_q <= valid_d;
      prune_q <= prune_d;
    end
  end

  assign busy       = (state_q == S_FETCH) || (state_q == S_NEXT);
  assign W          = w_q;
  assign J          = j_q;
  assign MinCost    = min_q;
  assign MatchCount = cnt_q;
  assign BestPerm   = best_q;
  assign Valid      = valid_q;

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised job-assignment machine. Performs an exhaustive search over all N! worker-to-job permutations, reading each cost from an external cost table through the W/J/Cost interface.
- Reports the minimum total cost, the number of permutations that reach it, and the lexicographically smallest optimal assignment.
- Adds a start/busy handshake so the block can be rerun without reset.
- Adds an optional prune mode that stops accumulating a permutation as soon as its partial sum already exceeds the best sum found.
- Sits beside the cost-table ROM/RAM in the accelerator datapath.

Parameters:
N, 8, number of workers and jobs; legal range 2..8
CW, 7, cost word width
IW, $clog2(N), index width of W, J and each permutation element
SW, CW+$clog2(N), width of total-cost sums
MCW, 16, MatchCount width; 16 is sufficient for N!≤40320

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a search; sampled only in IDLE or DONE
prune_en  in  1  enables early abort of a permutation; sampled with start
busy  out  1  high while a search runs
W  out  IW  worker index presented to the cost table
J  out  IW  job index presented to the cost table
Cost  in  CW  cost of (W,J); combinational from W/J, sampled at the end of the cycle W/J are held
MinCost  out  SW  minimum total cost
MatchCount  out  MCW  number of permutations with total equal to MinCost
BestPerm  out  N*IW  job index for worker k in bits [k*IW +: IW]
Valid  out  1  results final; held until the next accepted start

Behaviour:
- Reset values: busy=0, W=0, J=0, MinCost=all ones, MatchCount=0, BestPerm=0, Valid=0, FSM in IDLE. Internal permutation register holds identity (perm[k]=k).
- Reset asserted mid-search aborts immediately to the reset state. No partial results survive.
- FSM states are IDLE, FETCH, NEXT, DONE.
- IDLE/DONE + start:
  - clear accumulator; MinCost=all ones; MatchCount=0; Valid=0; busy=1
  - latch prune_en
  - W=0, J=perm[0] with perm=identity
  - go to FETCH
- FETCH, one cycle per worker:
  - acc_next = acc + Cost, computed at SW width with no overflow possible
  - If W<N-1 and not pruned: W=W+1, J=perm[W+1], acc=acc_next.
  - Prune condition: latched prune_en=1 and acc_next > MinCost (strictly greater). On prune, go to NEXT and skip the compare.
  - Equality never prunes, so MatchCount stays exact.
  - If W==N-1, compare acc_next against MinCost:
    - if less: MinCost=acc_next, MatchCount=1, BestPerm=perm
    - if equal: MatchCount+1
    - then go to NEXT
- NEXT:
  - Apply lexicographic next-permutation to perm: find pivot, swap with the smallest larger element to its right, reverse the suffix.
  - Reset acc=0, W=0, J=next perm[0], then go to FETCH.
  - If perm is the last (descending) permutation: go to DONE, Valid=1, busy=0, W=J=0.
- DONE: results hold. A new start restarts the search with Valid cleared on the same edge.
- start while busy is ignored.
- Latency without prune: each permutation takes N FETCH cycles plus 1 NEXT cycle. Valid rises exactly N!·(N+1) rising edges after the edge that accepted start.
- With prune, the cycle count is ≤ the unpruned count and the results are identical.
- Because enumeration is lexicographic and ties never replace BestPerm, BestPerm is the lexicographically first optimum.

Decomposition:
- Package jam_pkg:
  - FSM state enum
  - functions for the IW/SW width calculations
  - factorial constant function used for MCW sizing checks and by the bench
- One sub-module, jam_next_perm: combinational, takes N*IW perm in, returns N*IW next perm plus an is_last flag. Parameter N.

Test Plan:
- N=8, Cost=W+J, prune off → MinCost=56, MatchCount=40320, BestPerm=identity {7,6,5,4,3,2,1,0} packed; Valid at edge 362880 after start.
- N=8, Cost=(W==J)?0:10 → MinCost=0, MatchCount=1, BestPerm=identity; repeat with prune on → same results in fewer cycles.
- N=4, constant Cost=5 → MinCost=20, MatchCount=24, BestPerm=identity; Valid exactly 120 edges after start.
- N=4, anti-diagonal matrix (Cost=0 when J==3-W, else 9), prune on and off → MinCost=0, MatchCount=1, BestPerm={0,1,2,3} for workers 3..0 (worker0→job3).
- Random 8×8 matrix compared against the bench golden model; second start issued in DONE reruns with a new matrix; start pulsed while busy is ignored.
- RST asserted mid-FETCH → all outputs return to reset values within the same cycle; a following start produces correct results.
